mac_feeder: RTL and testbench
=============================

# mac_feeder

Upstream operand feeder for the parallel MAC. Accepts operand pairs one byte-pair at a time from the host side and buffers one complete vector of VEC_LEN pairs. It then issues a single-cycle start to the MAC and streams the vector as PARALLEL-lane beats on consecutive cycles. It holds off the next vector until the MAC reports done.

## Interface
- PARALLEL, 1: lanes per beat; must match the MAC's lane count; 1..8.
- VEC_LEN, 25: operand pairs per vector; 1..63.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  host operand pair valid.
- wr_ready  out  1  feeder can accept a pair this cycle.
- wr_a, wr_b  in  8 each  operand pair, unsigned.
- mac_start  out  1  one-cycle start pulse to the MAC.
- mac_din_a, mac_din_b  out  PARALLEL*8 each  beat lanes.
- mac_done  in  1  MAC completion pulse.
- busy  out  1  FSM is not in IDLE.
- vec_cnt  out  16  vectors completed; wraps at 0xFFFF -> 0.

## Operation
- Derived constant: BEATS = ceil(VEC_LEN/PARALLEL).
- Write side:
  - A pair is accepted when wr_valid && wr_ready. It is stored at wr_ptr of the fill bank, and wr_ptr increments.
  - On the pair at wr_ptr == VEC_LEN-1: wr_ptr wraps to 0 and the fill bank is marked full.
  - wr_ready = !full[fill bank], combinational from registered flags.
- FSM states and transitions:
  - IDLE: moves to START when the stream bank is full.
  - START: mac_start = 1 for this cycle only; moves to STREAM.
  - STREAM: beat counter k runs 0..BEATS-1, one beat per cycle; moves to WAIT_DONE after k == BEATS-1.
  - WAIT_DONE: on mac_done, clear full[stream bank], increment vec_cnt, move to IDLE.
- Beat mapping:
  - Lane j of beat k carries element k*PARALLEL+j at bits [8j+7:8j].
  - Elements with index >= VEC_LEN are driven as 0x00, so padding adds nothing.
- mac_din_a and mac_din_b are 0 in every state other than STREAM.
- mac_done is ignored in IDLE, START and STREAM. No counting or state change results.
- Simultaneous events:
  - A bank release (mac_done) and a write attempt in the same cycle: the write is refused if that bank was full that cycle. wr_ready rises on the next cycle.
  - A bank becoming full in the same cycle the FSM is in IDLE: START is entered one cycle later, because the full flag is registered.
- Reset, including mid-vector or mid-stream:
  - FSM returns to IDLE; every full flag and wr_ptr clears; the fill and stream bank selects return to 0.
  - Partially written data is discarded.
  - The MAC shares rst, so both blocks restart together.
- Reset values: wr_ready = 1, mac_start = 0, mac_din_a = 0, mac_din_b = 0, busy = 0, vec_cnt = 0.

## Timing
- mac_start is registered (high while in START).
- Beat k is presented during cycle S+1+k, where S is the mac_start cycle. The MAC captures it at the end of that cycle.
- Last beat is presented at cycle S+BEATS.
- Start-to-start minimum is BEATS + 2 + D cycles, where D is the cycles spent in WAIT_DONE up to and including the mac_done cycle, plus the IDLE cycle.
- Write latency: the last pair is accepted at cycle W; mac_start is asserted no earlier than W+2.
- Throughput: one pair per cycle on the write side while wr_ready is high.

## Configuration
- MAC_FEEDER_PINGPONG_EN defined:
  - Two banks. fill_sel toggles when a bank fills; stream_sel toggles when a bank is released.
  - Loading vector n+1 overlaps streaming of vector n.
  - wr_ready drops only when both banks are full.
- MAC_FEEDER_PINGPONG_EN undefined:
  - One bank. wr_ready is low from the moment the bank fills until the mac_done release.
  - Behaviour is otherwise identical.

## Structure
- Shared package mac_pkg holds:
  - the feeder state enum (IDLE, START, STREAM, WAIT_DONE);
  - a ceil-divide function used for BEATS;
  - default PARALLEL and VEC_LEN constants shared with the MAC.
- One sub-module, mac_feeder_bank: a VEC_LEN x 16-bit register file with a single byte-pair write port and a PARALLEL-lane read port addressed by beat index, applying zero padding.
- The top level instantiates one or two mac_feeder_bank instances depending on the macro.

## Test plan
- PARALLEL=1, VEC_LEN=25, write a=1..25 with b=1 -> one mac_start pulse; 25 beats carrying 1..25; MAC dout = 325 at done; vec_cnt = 1.
- PARALLEL=4, VEC_LEN=25, a=b=2 -> 7 beats; beat 6 has lane 0 = 0x02 and lanes 1..3 = 0x00; dout = 100.
- Pingpong on, write vectors A (a=b=1) and B (a=b=3) back-to-back:
  - wr_ready never drops during A's stream;
  - second mac_start occurs 2 cycles after the first mac_done;
  - dout = 25 and then 225.
- Pingpong off, attempt a write during STREAM -> wr_ready = 0 and the pair is not stored; wr_ready = 1 the cycle after mac_done.
- Assert rst during beat 10 of 25 -> next cycle all outputs are at reset values; re-loading a=1..25, b=1 gives dout = 325.
- Spurious mac_done pulse in IDLE and in STREAM -> vec_cnt unchanged, stream continues uninterrupted; a write of 0xFF x 0xFF pairs with vec_cnt preset near wrap shows 0xFFFF -> 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC feeder and the parallel MAC.
// Holds the feeder state enum, sizing helpers and the default lane/vector sizes.
package mac_pkg;

  localparam int DEFAULT_PARALLEL = 1;
  localparam int DEFAULT_VEC_LEN  = 25;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_e;

  // Number of beats needed to carry num elements over den lanes.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_feeder_bank.sv
// One vector buffer: VEC_LEN 16-bit entries {a, b}, written one pair at a time
// and read as a PARALLEL-lane beat. Lanes past the end of the vector read as zero.
module mac_feeder_bank
  import mac_pkg::*;
#(
  parameter int PARALLEL = DEFAULT_PARALLEL,
  parameter int VEC_LEN  = DEFAULT_VEC_LEN,
  localparam int BEATS   = ceil_div(VEC_LEN, PARALLEL),
  localparam int AW      = idx_bits(VEC_LEN),
  localparam int BW      = idx_bits(BEATS)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [7:0]              wr_a,
  input  logic [7:0]              wr_b,
  input  logic [BW-1:0]           rd_beat,
  output logic [PARALLEL*8-1:0]   rd_a,
  output logic [PARALLEL*8-1:0]   rd_b
);

  logic [15:0] mem [VEC_LEN];
  int          elem;

  // Store the accepted operand pair; no reset, a bank is only read once marked full.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_a, wr_b};
    end
  end

  // Gather the lanes of the requested beat, padding past the vector end with zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    elem = 0;
    for (int j = 0; j < PARALLEL; j++) begin
      elem = int'(rd_beat) * PARALLEL + j;
      if (elem < VEC_LEN) begin
        rd_a[8*j +: 8] = mem[elem][15:8];
        rd_b[8*j +: 8] = mem[elem][7:0];
      end
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// Operand feeder for the parallel MAC: buffers a vector of VEC_LEN byte pairs,
// pulses mac_start, streams BEATS beats of PARALLEL lanes, then waits for mac_done.
// Define MAC_FEEDER_PINGPONG_EN for two banks so loading overlaps streaming.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int PARALLEL = DEFAULT_PARALLEL,
  parameter int VEC_LEN  = DEFAULT_VEC_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [7:0]            wr_a,
  input  logic [7:0]            wr_b,
  output logic                  mac_start,
  output logic [PARALLEL*8-1:0] mac_din_a,
  output logic [PARALLEL*8-1:0] mac_din_b,
  input  logic                  mac_done,
  output logic                  busy,
  output logic [15:0]           vec_cnt
);

  localparam int BEATS = ceil_div(VEC_LEN, PARALLEL);
  localparam int AW    = idx_bits(VEC_LEN);
  localparam int BW    = idx_bits(BEATS);

  feeder_state_e         state_q, state_d;
  logic [AW-1:0]         wr_ptr_q;
  logic [BW-1:0]         beat_q;
  logic [15:0]           vec_cnt_q;
  logic                  fill_full, stream_full;
  logic                  wr_fire, last_pair, bank_release;
  logic [PARALLEL*8-1:0] rd_a, rd_b;

  assign wr_ready     = !fill_full;
  assign wr_fire      = wr_valid && wr_ready;
  assign last_pair    = wr_fire && (wr_ptr_q == AW'(VEC_LEN - 1));
  assign bank_release = (state_q == WAIT_DONE) && mac_done;
  assign busy         = (state_q != IDLE);
  assign vec_cnt      = vec_cnt_q;

  // Write pointer walks the fill bank and wraps after the last pair of a vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
    end else if (last_pair) begin
      wr_ptr_q <= '0;
    end else if (wr_fire) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
    end
  end

`ifdef MAC_FEEDER_PINGPONG_EN
  logic [1:0]            full_q;
  logic                  fill_sel, stream_sel;
  logic [PARALLEL*8-1:0] rd_a0, rd_b0, rd_a1, rd_b1;

  assign fill_full   = full_q[fill_sel];
  assign stream_full = full_q[stream_sel];
  assign rd_a        = stream_sel ? rd_a1 : rd_a0;
  assign rd_b        = stream_sel ? rd_b1 : rd_b0;

  // Fill completes a bank and hands over to the other; release frees the streamed bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      fill_sel   <= 1'b0;
      stream_sel <= 1'b0;
    end else begin
      if (last_pair) begin
        full_q[fill_sel] <= 1'b1;
        fill_sel         <= !fill_sel;
      end
      if (bank_release) begin
        full_q[stream_sel] <= 1'b0;
        stream_sel         <= !stream_sel;
      end
    end
  end

  mac_feeder_bank #(.PARALLEL(PARALLEL), .VEC_LEN(VEC_LEN)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_fire && !fill_sel),
    .wr_addr (wr_ptr_q),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .rd_beat (beat_q),
    .rd_a    (rd_a0),
    .rd_b    (rd_b0)
  );

  mac_feeder_bank #(.PARALLEL(PARALLEL), .VEC_LEN(VEC_LEN)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_fire && fill_sel),
    .wr_addr (wr_ptr_q),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .rd_beat (beat_q),
    .rd_a    (rd_a1),
    .rd_b    (rd_b1)
  );
`else
  logic full_q;

  assign fill_full   = full_q;
  assign stream_full = full_q;

  // The single bank is full from its last pair until the MAC releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else if (last_pair) begin
      full_q <= 1'b1;
    end else if (bank_release) begin
      full_q <= 1'b0;
    end
  end

  mac_feeder_bank #(.PARALLEL(PARALLEL), .VEC_LEN(VEC_LEN)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .rd_beat (beat_q),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );
`endif

  // State register, beat counter, registered start pulse and completed-vector count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      mac_start <= 1'b0;
      vec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mac_start <= (state_d == START);
      if (state_q == STREAM) begin
        beat_q <= beat_q + BW'(1);
      end else begin
        beat_q <= '0;
      end
      if (bank_release) begin
        vec_cnt_q <= vec_cnt_q + 16'd1;
      end
    end
  end

  // Next-state decode; beat data reaches the MAC only while streaming.
  always_comb begin
    state_d   = state_q;
    mac_din_a = '0;
    mac_din_b = '0;
    case (state_q)
      IDLE: begin
        if (stream_full) begin
          state_d = START;
        end
      end
      START: begin
        state_d = STREAM;
      end
      STREAM: begin
        mac_din_a = rd_a;
        mac_din_b = rd_b;
        if (beat_q == BW'(BEATS - 1)) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mac_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder with 4 lanes and 25-pair vectors (7 beats, last beat padded).
// A vector-level model predicts every output each cycle; the bench also plays the MAC.
module tb_mac_feeder;

  localparam int P     = 4;
  localparam int V     = 25;
  localparam int BEATS = (V + P - 1) / P;
`ifdef MAC_FEEDER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_valid;
  logic           wr_ready;
  logic [7:0]     wr_a, wr_b;
  logic           mac_start;
  logic [P*8-1:0] mac_din_a, mac_din_b;
  logic           mac_done;
  logic           busy;
  logic [15:0]    vec_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mac_feeder #(.PARALLEL(P), .VEC_LEN(V)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .mac_start (mac_start),
    .mac_din_a (mac_din_a),
    .mac_din_b (mac_din_b),
    .mac_done  (mac_done),
    .busy      (busy),
    .vec_cnt   (vec_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index used to measure start-to-done spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Vector-level model: complete vectors wait in a queue, tl is cycles since mac_start.
  logic [15:0] m_words [$];
  logic [15:0] m_cur [V];
  int          m_fill = 0;
  int          m_tl   = -1;
  logic [15:0] m_cnt  = 16'd0;
  bit          live   = 1'b0;
  bit          preset_req;
  int          old_vecs;

  always @(posedge clk) begin
    if (rst) begin
      m_words.delete();
      m_fill = 0;
      m_tl   = -1;
      m_cnt  = 16'd0;
      live   = 1'b1;
    end else begin
      old_vecs = m_words.size() / V;
      if (preset_req) m_cnt = 16'hFFFE;
      if (m_tl < 0) begin
        if (old_vecs > 0) m_tl = 0;
      end else if (m_tl <= BEATS) begin
        m_tl++;
      end else if (mac_done) begin
        for (int i = 0; i < V; i++) void'(m_words.pop_front());
        m_cnt = m_cnt + 16'd1;
        m_tl  = -1;
      end
      if (wr_valid && old_vecs < NB) begin
        m_cur[m_fill] = {wr_a, wr_b};
        m_fill++;
        if (m_fill == V) begin
          for (int i = 0; i < V; i++) m_words.push_back(m_cur[i]);
          m_fill = 0;
        end
      end
    end
  end

  // Compare every DUT output against the model in the middle of each cycle.
  logic [P*8-1:0] exp_a, exp_b;
  always @(negedge clk) begin
    if (live) begin
      exp_a = '0;
      exp_b = '0;
      if (m_tl >= 1 && m_tl <= BEATS) begin
        for (int j = 0; j < P; j++) begin
          if ((m_tl - 1) * P + j < V) begin
            exp_a[8*j +: 8] = m_words[(m_tl - 1) * P + j][15:8];
            exp_b[8*j +: 8] = m_words[(m_tl - 1) * P + j][7:0];
          end
        end
      end
      checkOutput("mac_start", 32'(mac_start), 32'(m_tl == 0));
      checkOutput("busy", 32'(busy), 32'(m_tl >= 0));
      checkOutput("wr_ready", 32'(wr_ready), 32'((m_words.size() / V) < NB));
      checkOutput("vec_cnt", 32'(vec_cnt), 32'(m_cnt));
      checkOutput("mac_din_a", 32'(mac_din_a), 32'(exp_a));
      checkOutput("mac_din_b", 32'(mac_din_b), 32'(exp_b));
    end
  end

  // Behaves as the MAC: sums lane products over the beats following each start.
  bit             mac_arm = 1'b0;
  int             mac_k, mac_acc, mac_res;
  int             mac_results = 0;
  int             drop_cnt = 0;
  logic [P*8-1:0] last_a;
  always @(negedge clk) begin
    if (!busy) begin
      mac_arm = 1'b0;
    end else if (mac_start) begin
      mac_arm = 1'b1;
      mac_acc = 0;
      mac_k   = 0;
    end else if (mac_arm) begin
      for (int j = 0; j < P; j++) mac_acc += int'(mac_din_a[8*j +: 8]) * int'(mac_din_b[8*j +: 8]);
      if (!wr_ready) drop_cnt++;
      if (mac_k == BEATS - 1) begin
        last_a  = mac_din_a;
        mac_res = mac_acc;
        mac_results++;
        mac_arm = 1'b0;
      end
      mac_k++;
    end
  end

  int consumed = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b);
    wr_valid = v;
    wr_a     = a;
    wr_b     = b;
    @(negedge clk);
  endtask

  task automatic write_pair(input logic [7:0] a, input logic [7:0] b);
    int g = 0;
    while (!wr_ready && g < 300) begin
      wr_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    if (g >= 300) checkOutput("wr_ready_timeout", 32'(wr_ready), 32'd1);
    applyStimulus(1'b1, a, b);
  endtask

  // kind 0: a = 1..V with b = 1; kind 1: a = b = c for every pair.
  task automatic write_vector(input int kind, input logic [7:0] c);
    for (int i = 0; i < V; i++) begin
      if (kind == 0) write_pair(8'(i + 1), 8'd1);
      else           write_pair(c, c);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_start();
    int g = 0;
    while (!mac_start && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) checkOutput("start_timeout", 32'(mac_start), 32'd1);
    start_cyc = cyc;
  endtask

  task automatic finish_vector(input int exp_dout, input string name);
    int g = 0;
    while (mac_results == consumed && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) checkOutput("result_timeout", 32'(mac_results), 32'(consumed + 1));
    @(negedge clk);
    mac_done = 1'b1;
    done_cyc = cyc;
    @(negedge clk);
    mac_done = 1'b0;
    consumed = mac_results;
    checkOutput(name, 32'(mac_res), 32'(exp_dout));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_a = '0; wr_b = '0; mac_done = 1'b0; preset_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_mac_start", 32'(mac_start), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    checkOutput("rst_din_a", 32'(mac_din_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] spurious done in IDLE");
    mac_done = 1'b1;
    @(negedge clk);
    mac_done = 1'b0;
    @(negedge clk);
    checkOutput("idle_done_vec_cnt", 32'(vec_cnt), 32'd0);
    checkOutput("idle_done_busy", 32'(busy), 32'd0);

    $display("[TB] ramp vector a=1..25 b=1");
    write_vector(0, 8'd0);
    finish_vector(325, "dout_ramp");
    checkOutput("vec_cnt_1", 32'(vec_cnt), 32'd1);

    $display("[TB] a=b=2 vector, padded last beat");
    write_vector(1, 8'd2);
`ifndef MAC_FEEDER_PINGPONG_EN
    wait_start();
    repeat (2) @(negedge clk);
    checkOutput("stream_wr_ready", 32'(wr_ready), 32'd0);
    applyStimulus(1'b1, 8'hAA, 8'h55);
    wr_valid = 1'b0;
`endif
    finish_vector(100, "dout_twos");
    checkOutput("last_beat_a", 32'(last_a), 32'h0000_0002);
    checkOutput("ready_after_done", 32'(wr_ready), 32'd1);
    checkOutput("vec_cnt_2", 32'(vec_cnt), 32'd2);

    $display("[TB] spurious done during STREAM");
    write_vector(0, 8'd0);
    wait_start();
    repeat (3) @(negedge clk);
    mac_done = 1'b1;
    @(negedge clk);
    mac_done = 1'b0;
    checkOutput("stream_done_busy", 32'(busy), 32'd1);
    finish_vector(325, "dout_spurious");
    checkOutput("vec_cnt_3", 32'(vec_cnt), 32'd3);

    $display("[TB] reset during beat 3");
    write_vector(1, 8'd1);
    wait_start();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_mac_start", 32'(mac_start), 32'd0);
    checkOutput("midrst_din_a", 32'(mac_din_a), 32'd0);
    checkOutput("midrst_din_b", 32'(mac_din_b), 32'd0);
    checkOutput("midrst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("midrst_vec_cnt", 32'(vec_cnt), 32'd0);
    write_vector(0, 8'd0);
    finish_vector(325, "dout_after_rst");
    checkOutput("vec_cnt_after_rst", 32'(vec_cnt), 32'd1);

`ifdef MAC_FEEDER_PINGPONG_EN
    $display("[TB] ping-pong vectors A and B");
    begin
      int d0;
      d0 = drop_cnt;
      write_vector(1, 8'd1);
      write_vector(1, 8'd3);
      checkOutput("pp_ready_during_stream", 32'(drop_cnt), 32'(d0));
      finish_vector(25, "dout_pp_a");
      wait_start();
      checkOutput("pp_start_gap", 32'(start_cyc - done_cyc), 32'd2);
      finish_vector(225, "dout_pp_b");
    end
`endif

    $display("[TB] vec_cnt wrap with 0xFF pairs");
    @(negedge clk);
    preset_req = 1'b1;
    @(posedge clk);
    #1;
    force dut.vec_cnt_q = 16'hFFFE;
    #1;
    release dut.vec_cnt_q;
    preset_req = 1'b0;
    @(negedge clk);
    checkOutput("preset_vec_cnt", 32'(vec_cnt), 32'h0000_FFFE);
    write_vector(1, 8'hFF);
    finish_vector(1625625, "dout_ff_1");
    checkOutput("vec_cnt_ffff", 32'(vec_cnt), 32'h0000_FFFF);
    write_vector(1, 8'hFF);
    finish_vector(1625625, "dout_ff_2");
    checkOutput("vec_cnt_wrap", 32'(vec_cnt), 32'h0000_0000);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
